timer_mode_controller: RTL

- Front-end sequencer for the stopwatch/timer/clock datapath. It conditions the three raw buttons (splitOrReset, modeInput, startOrStop) and runs the mode state machine (timer, stopwatch, clock, alarm-set).
- Drives the datapath's run/clear/lap/edit controls and owns the alarm ring/dismiss logic, so the counting datapath contains no button handling.

---
 rtl/timer_mode_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/timer_mode_controller.sv
// rtl/timer_mode_controller.sv - button conditioning and mode/sub-state sequencer (optional AUTO_RING_TIMEOUT_EN)
module timer_mode_controller #(
  parameter int DEBOUNCE_CYCLES     = 2,
  parameter int LONG_PRESS_CYCLES   = 200,
  parameter int FIELD_COUNT         = 6,
  parameter int RING_TIMEOUT_CYCLES = 6000
) (
  input  logic       clockSignal,
  input  logic       resetN,
  input  logic       splitOrReset,
  input  logic       modeInput,
  input  logic       startOrStop,
  input  logic       countdownDone,
  input  logic       alarmMatch,
  output logic [1:0] mode,
  output logic       runEnable,
  output logic       clearCount,
  output logic       lapHold,
  output logic       editActive,
  output logic [2:0] editIndex,
  output logic       editIncrement,
  output logic       editCommit,
  output logic       alarmArmed,
  output logic       ringSound
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [2:0] LAST_FIELD = 3'(FIELD_COUNT - 1);

  localparam logic [1:0] M_TIMER     = 2'd0;
  localparam logic [1:0] M_STOPWATCH = 2'd1;
  localparam logic [1:0] M_ALARM     = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EDIT} sub_state_t;
  sub_state_t state;

  // bit 0 = modeInput, bit 1 = startOrStop, bit 2 = splitOrReset
  logic [2:0] raw;
  logic [2:0] sync1, sync2, level, level_d, press;
  logic [DB_W-1:0] db_cnt [3];

  logic [LP_W-1:0] lp_cnt;
  logic lp_fired, split_long, split_short, split_rel;
  logic split_swallow;

  logic ring_evt, any_press, dismiss;
  logic ev_mode, ev_start, ev_short, ev_long;

  assign raw = {splitOrReset, startOrStop, modeInput};

  // Synchronise, debounce and edge-detect all three buttons.
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Split hold timer: one long event per hold, short event on release only if no long fired.
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      lp_cnt      <= '0;
      lp_fired    <= 1'b0;
      split_long  <= 1'b0;
      split_short <= 1'b0;
      split_rel   <= 1'b0;
    end else begin
      split_long  <= 1'b0;
      split_short <= 1'b0;
      split_rel   <= 1'b0;
      if (level[2]) begin
        if (!lp_fired) begin
          if (lp_cnt == LP_W'(LONG_PRESS_CYCLES - 1)) begin
            split_long <= 1'b1;
            lp_fired   <= 1'b1;
          end else begin
            lp_cnt <= lp_cnt + 1'b1;
          end
        end
      end else begin
        lp_cnt   <= '0;
        lp_fired <= 1'b0;
        if (level_d[2]) begin
          split_rel   <= 1'b1;
          split_short <= ~lp_fired;
        end
      end
    end
  end

  assign ring_evt  = (countdownDone && mode == M_TIMER && state == S_RUN) ||
                     (alarmMatch && alarmArmed);
  assign any_press = |press;
  // A press that silences the ring does nothing else, unless a new ring arrives alongside it.
  assign dismiss   = ringSound && any_press && !ring_evt;
  assign ev_mode   = press[0] && !dismiss;
  assign ev_start  = press[1] && !dismiss && !press[0];
  assign ev_short  = split_short && !dismiss && !press[0] && !press[1] && !split_swallow;
  assign ev_long   = split_long  && !dismiss && !press[0] && !press[1] && !split_swallow;

  assign runEnable  = (state == S_RUN);
  assign editActive = (state == S_EDIT);

`ifdef AUTO_RING_TIMEOUT_EN
  logic [$clog2(RING_TIMEOUT_CYCLES+1)-1:0] ring_cnt;
`else
  logic unused_ring_timeout;
  assign unused_ring_timeout = (RING_TIMEOUT_CYCLES != 0);
`endif

  // Mode and sub-state sequencer with ring ownership and one-cycle control pulses.
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      state         <= S_IDLE;
      mode          <= M_TIMER;
      lapHold       <= 1'b0;
      editIndex     <= '0;
      clearCount    <= 1'b0;
      editIncrement <= 1'b0;
      editCommit    <= 1'b0;
      alarmArmed    <= 1'b0;
      ringSound     <= 1'b0;
      split_swallow <= 1'b0;
`ifdef AUTO_RING_TIMEOUT_EN
      ring_cnt      <= '0;
`endif
    end else begin
      clearCount    <= 1'b0;
      editIncrement <= 1'b0;
      editCommit    <= 1'b0;

      if (split_rel) split_swallow <= 1'b0;
      if (dismiss) begin
        ringSound <= 1'b0;
        if (press[2]) split_swallow <= 1'b1;
      end

      if (ev_mode) begin
        if (state == S_EDIT) begin
          editCommit <= 1'b1;
        end else begin
          mode    <= mode + 2'd1;
          lapHold <= 1'b0;
        end
        state <= S_IDLE;
      end else if (ev_start) begin
        case (state)
          S_EDIT:   editIncrement <= 1'b1;
          S_RUN:    state <= S_PAUSED;
          S_PAUSED: state <= S_RUN;
          default: begin
            if (mode == M_TIMER || mode == M_STOPWATCH) state <= S_RUN;
            else if (mode == M_ALARM) alarmArmed <= ~alarmArmed;
          end
        endcase
      end else if (ev_short) begin
        case (state)
          S_EDIT:   editIndex <= (editIndex == LAST_FIELD) ? 3'd0 : editIndex + 3'd1;
          S_RUN:    if (mode == M_STOPWATCH) lapHold <= ~lapHold;
          S_PAUSED: begin
            clearCount <= 1'b1;
            lapHold    <= 1'b0;
            state      <= S_IDLE;
          end
          default: ;
        endcase
      end else if (ev_long) begin
        if (state == S_EDIT) begin
          state <= S_IDLE;
        end else if (state == S_IDLE && mode != M_STOPWATCH) begin
          state     <= S_EDIT;
          editIndex <= '0;
        end
      end

      if (countdownDone && mode == M_TIMER && state == S_RUN) state <= S_IDLE;

`ifdef AUTO_RING_TIMEOUT_EN
      if (ring_evt) begin
        ring_cnt <= '0;
      end else if (ringSound) begin
        if (ring_cnt == $bits(ring_cnt)'(RING_TIMEOUT_CYCLES - 1)) ringSound <= 1'b0;
        else ring_cnt <= ring_cnt + 1'b1;
      end
`endif

      if (ring_evt) ringSound <= 1'b1;
    end
  end

endmodule
